// File: rtl/poly_note_player_pkg.sv
// Shared types and width helpers for the polyphonic note player.
package poly_note_player_pkg;

  localparam int SINE_ADDR_W = 10;
  localparam int SINE_DATA_W = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DRAIN,
    S_DONE
  } mix_state_t;

  function automatic int vsel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int phase_w(input int step_w);
    return step_w + 2;
  endfunction

  // One extra bit per doubling of the voice count keeps the mix sum exact.
  function automatic int acc_w(input int n);
    return SINE_DATA_W + $clog2(n);
  endfunction

endpackage

// File: rtl/poly_note_player_if.sv
// Sequencer/codec-facing signal bundle of the polyphonic note player.
interface poly_note_player_if #(
  parameter int NUM_VOICES = 4,
  parameter int NOTE_W     = 6,
  parameter int DUR_W      = 6,
  parameter int SAMPLE_W   = 18
);
  localparam int VSEL_W = poly_note_player_pkg::vsel_w(NUM_VOICES);

  logic                       play_enable;
  logic                       load_new_note;
  logic [VSEL_W-1:0]          voice_sel;
  logic [NOTE_W-1:0]          note_to_load;
  logic [DUR_W-1:0]           duration;
  logic                       beat;
  logic                       generate_next_sample;
  logic signed [SAMPLE_W-1:0] sample_out;
  logic                       sample_ready;
  logic [NUM_VOICES-1:0]      note_done;
  logic                       busy;

  modport master (
    output play_enable, load_new_note, voice_sel, note_to_load, duration,
           beat, generate_next_sample,
    input  sample_out, sample_ready, note_done, busy
  );

  modport slave (
    input  play_enable, load_new_note, voice_sel, note_to_load, duration,
           beat, generate_next_sample,
    output sample_out, sample_ready, note_done, busy
  );

endinterface

// File: rtl/frequency_rom.sv
// Note index to phase step; one note unit advances the sine address by one entry.
module frequency_rom #(
  parameter int NOTE_W = 6,
  parameter int STEP_W = 20
) (
  input  logic [NOTE_W-1:0] i_note,
  output logic [STEP_W-1:0] o_step
);

  assign o_step = STEP_W'(i_note) << (STEP_W - 8);

endmodule

// File: rtl/poly_note_player_voice_counter.sv
// Per-voice beat-driven duration counter with a registered zero flag.
module voice_counter
  import poly_note_player_pkg::*;
#(
  parameter int DUR_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [DUR_W-1:0] i_duration,
  input  logic             i_beat,
  input  logic             i_enable,
  output logic             o_done
);

  logic [DUR_W-1:0] r_count;
  logic [DUR_W-1:0] w_count_nxt;

  // A load in the same cycle as a beat takes the loaded value undecremented.
  always_comb begin
    w_count_nxt = r_count;
    if (i_load)
      w_count_nxt = i_duration;
    else if (i_beat && i_enable && (r_count != '0))
      w_count_nxt = r_count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= '0;
      o_done  <= 1'b1;
    end else begin
      r_count <= w_count_nxt;
      o_done  <= (w_count_nxt == '0);
    end
  end

endmodule

// File: rtl/sine_rom.sv
// 1024-entry signed sine table (parabolic half-wave), registered read.
module sine_rom
  import poly_note_player_pkg::*;
(
  input  logic                          clk,
  input  logic [SINE_ADDR_W-1:0]        i_addr,
  output logic signed [SINE_DATA_W-1:0] o_data
);

  logic [SINE_ADDR_W-2:0] w_x;
  logic [SINE_DATA_W-1:0] w_mag;

  // x*(511-x)/2 peaks at 32640, so the magnitude always fits the signed range.
  assign w_x   = i_addr[SINE_ADDR_W-2:0];
  assign w_mag = SINE_DATA_W'((32'(w_x) * (32'd511 - 32'(w_x))) >> 1);

  always_ff @(posedge clk) begin
    o_data <= i_addr[SINE_ADDR_W-1] ? -$signed(w_mag) : $signed(w_mag);
  end

endmodule

// File: rtl/poly_note_player.sv
// Multi-voice note player: per-voice phase/step/duration state and a
// time-multiplexed sine lookup that mixes all voices into one sample per request.
module poly_note_player
  import poly_note_player_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int NOTE_W     = 6,
  parameter int DUR_W      = 6,
  parameter int STEP_W     = 20,
  parameter int SAMPLE_W   = 18
) (
  input logic               clk,
  input logic               reset,
  poly_note_player_if.slave bus
);

  localparam int VSEL_W  = vsel_w(NUM_VOICES);
  localparam int PHASE_W = phase_w(STEP_W);
  localparam int ACC_W   = acc_w(NUM_VOICES);
  localparam logic [VSEL_W-1:0] LAST_K = VSEL_W'(NUM_VOICES - 1);

  mix_state_t                     r_state, w_state_nxt;
  logic [VSEL_W-1:0]              r_k;
  logic [NOTE_W-1:0]              r_note  [NUM_VOICES];
  logic [STEP_W-1:0]              r_step  [NUM_VOICES];
  logic [PHASE_W-1:0]             r_phase [NUM_VOICES];
  logic [NUM_VOICES-1:0]          w_done, w_active, w_load, w_adv;
  logic [31:0]                    w_sel_ext;
  logic                           w_sel_ok, w_start, w_busy, w_ready;
  logic                           r_ld_vld_p1;
  logic [VSEL_W-1:0]              r_ld_sel_p1;
  logic [NOTE_W-1:0]              r_ld_note_p1;
  logic [STEP_W-1:0]              w_freq_step;
  logic [SINE_ADDR_W-1:0]         w_sine_addr;
  logic signed [SINE_DATA_W-1:0]  w_sine_data;
  logic                           r_vld_p1;
  logic signed [ACC_W-1:0]        r_acc, w_acc_nxt;
  logic signed [SAMPLE_W-1:0]     r_sample;

  function automatic logic signed [ACC_W-1:0] widen_rom(input logic signed [SINE_DATA_W-1:0] d);
    return ACC_W'(d);
  endfunction

  function automatic logic signed [SAMPLE_W-1:0] to_sample(input logic signed [ACC_W-1:0] a);
    return SAMPLE_W'(a);
  endfunction

  assign w_sel_ext = 32'(bus.voice_sel);
  assign w_sel_ok  = (w_sel_ext < 32'(NUM_VOICES));
  assign w_start   = (r_state == S_IDLE) && bus.generate_next_sample && bus.play_enable;

  always_comb begin
    w_load   = '0;
    w_active = '0;
    w_adv    = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      w_load[v]   = bus.load_new_note && w_sel_ok && (bus.voice_sel == VSEL_W'(v));
      w_active[v] = !w_done[v] && (r_note[v] != '0);
      w_adv[v]    = (r_state == S_SCAN) && (r_k == VSEL_W'(v)) && w_active[v];
    end
  end

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    voice_counter #(.DUR_W(DUR_W)) u_cnt (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_load[v]),
      .i_duration (bus.duration),
      .i_beat     (bus.beat),
      .i_enable   (bus.play_enable),
      .o_done     (w_done[v])
    );
  end

  // Load stage p1: frequency lookup for the voice loaded last cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ld_vld_p1  <= 1'b0;
      r_ld_sel_p1  <= '0;
      r_ld_note_p1 <= '0;
    end else begin
      r_ld_vld_p1  <= |w_load;
      r_ld_sel_p1  <= bus.voice_sel;
      r_ld_note_p1 <= bus.note_to_load;
    end
  end

  frequency_rom #(.NOTE_W(NOTE_W), .STEP_W(STEP_W)) u_freq (
    .i_note (r_ld_note_p1),
    .o_step (w_freq_step)
  );

  // A load clears the phase even when that voice is being advanced this cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        r_note[v]  <= '0;
        r_step[v]  <= '0;
        r_phase[v] <= '0;
      end
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (w_load[v]) begin
          r_note[v]  <= bus.note_to_load;
          r_phase[v] <= '0;
        end else if (w_adv[v]) begin
          r_phase[v] <= r_phase[v] + PHASE_W'(r_step[v]);
        end
        if (r_ld_vld_p1 && (r_ld_sel_p1 == VSEL_W'(v)))
          r_step[v] <= w_freq_step;
      end
    end
  end

  assign w_sine_addr = r_phase[r_k][PHASE_W-1 -: SINE_ADDR_W];

  sine_rom u_sine (
    .clk    (clk),
    .i_addr (w_sine_addr),
    .o_data (w_sine_data)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b1;
    w_ready     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (w_start) w_state_nxt = S_SCAN;
      end
      S_SCAN:  if (r_k == LAST_K) w_state_nxt = S_DRAIN;
      S_DRAIN: w_state_nxt = S_DONE;
      S_DONE: begin
        w_ready     = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_acc_nxt = r_vld_p1 ? (r_acc + widen_rom(w_sine_data)) : r_acc;

  // Mix stage p1: ROM word for the voice addressed last cycle joins the sum.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_k      <= '0;
      r_vld_p1 <= 1'b0;
      r_acc    <= '0;
      r_sample <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_vld_p1 <= (r_state == S_SCAN) && w_active[r_k];
      if (w_start)
        r_acc <= '0;
      else if (r_state == S_SCAN)
        r_acc <= w_acc_nxt;
      if (r_state == S_SCAN)
        r_k <= (r_k == LAST_K) ? '0 : r_k + 1'b1;
      if (r_state == S_DRAIN)
        r_sample <= to_sample(w_acc_nxt);
    end
  end

  assign bus.sample_out   = r_sample;
  assign bus.sample_ready = w_ready;
  assign bus.busy         = w_busy;
  assign bus.note_done    = w_done;

endmodule

// File: doc/poly_note_player.md
# poly_note_player

Parametrised multi-voice successor to the single-voice note player. Holds NUM_VOICES independent notes, each with its own beat-driven duration counter and phase accumulator, and on each codec request time-multiplexes one shared sine ROM across all voices to produce one mixed sample. It sits between the song/chord sequencer (note loads, `beat`) and the codec (`generate_next_sample`/`sample_ready`).

## Interface

Parameters:
- NUM_VOICES, 4: voice count, ≥1
- NOTE_W, 6: note index width; note 0 = rest
- DUR_W, 6: duration width, in beats
- STEP_W, 20: step-size width from frequency_rom
- SAMPLE_W, 18: mixed output width; must be ≥ 16+clog2(NUM_VOICES)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low
- play_enable  in  1  high: counters, phases and sample requests active
- load_new_note  in  1  one-cycle load strobe
- voice_sel  in  max(1,clog2(NUM_VOICES))  target voice for load
- note_to_load  in  NOTE_W  note index
- duration  in  DUR_W  note length in beats
- beat  in  1  1/48 s beat pulse
- generate_next_sample  in  1  codec sample request
- sample_out  out  SAMPLE_W  signed mixed sample, held between updates
- sample_ready  out  1  one-cycle pulse, sample_out valid
- note_done  out  NUM_VOICES  bit v high when voice v count == 0
- busy  out  1  mix sequence in progress

## Operation

- Per voice: note reg, step reg (STEP_W), phase acc (STEP_W+2 bits), duration count (DUR_W).
- Load (load_new_note, voice_sel < NUM_VOICES, regardless of play_enable): note ← note_to_load, count ← duration, phase ← 0; frequency_rom looked up with note, step written the following cycle. voice_sel ≥ NUM_VOICES: load ignored.
- Beat (beat && play_enable): every voice with count ≠ 0 decrements. A voice loaded in the same cycle takes the load value, no decrement.
- Voice v active iff count ≠ 0 and note ≠ 0. Inactive voices contribute 0, phase frozen.
- Mix FSM: IDLE → (generate_next_sample && play_enable) → SCAN → DRAIN → DONE → IDLE.
  - SCAN, cycle k (k = 0..N-1): sine_rom addr = phase_k[STEP_W+1:STEP_W-8] (10 bits); if voice k active, phase_k += step_k (mod 2^(STEP_W+2)).
  - ROM data (16-bit signed, 1-cycle) for voice k accumulated cycle k+1 (zeroed if voice k was inactive when addressed); accumulator width 16+clog2(N), cleared on entering SCAN.
  - DRAIN: last accumulate. DONE: sample_out ← sign-extended sum, sample_ready = 1.
- Requests while busy or play_enable low are dropped, not queued.
- Load to voice k in the cycle voice k is addressed: phase ← 0 wins over advance; contribution that cycle uses old phase.
- play_enable falling mid-mix: sequence completes normally.

## Timing

- Reset (reset == 0 at posedge): all counts/notes/steps/phases 0, FSM IDLE, sample_out 0, sample_ready 0, busy 0, note_done all-ones. Reset mid-mix abandons; no sample_ready.
- Request accepted at cycle t → busy high t+1..t+N+2, sample_ready high exactly at t+N+2, sample_out updated same edge.
- Minimum request spacing N+3 cycles.
- Load at t → note_done[v] reflects new count at t+1; step valid t+2; a voice addressed at t+1 uses stale step for that advance only.
- Back-to-back loads every cycle supported.
- note_done is a registered compare, zero extra latency beyond count.

## Structure

- Shared package: voice-index width function, PHASE_W = STEP_W+2, SINE_ADDR_W = 10, SINE_DATA_W = 16, FSM state enum.
- Reuse frequency_rom and sine_rom (one instance each, shared).
- Sub-module voice_counter: per-voice duration counter (load/beat/enable, count, done), instantiated NUM_VOICES times.
- Top holds phase/step arrays, mix FSM, accumulator.

## Test plan

- Reset held 3 cycles, release → sample_out 0, sample_ready 0, busy 0, note_done 4'b1111.
- Load voice 2, note 40, duration 3; 3 beats → note_done[2] low 3 beats, high after third; other bits stay 1.
- Voices 0,1 loaded same note, request → sample_ready at t+6 (N=4), sample_out = 2× single-voice sample (compare against single-voice run).
- Request at t and t+2 → exactly one sample_ready; beat with play_enable low → counts unchanged.
- Load voice 1 same cycle as beat with voice 0 count 5 → voice 1 = duration, voice 0 = 4; voice_sel 4 (N=4) → no state change.
- Duration 0 or note 0 load → voice contributes 0, phase stays 0 across 10 requests; reset mid-SCAN → no sample_ready, all state cleared.
